// File: rtl/register_file_mp.sv
// register_file_mp: two combinational read ports, two write ports and a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted write data onto the read ports.
module register_file_mp #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 16,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic              wr_a_en,
   input  logic [ADDR_W-1:0] wr_a_addr,
   input  logic [DATA_W-1:0] wr_a_data,
   input  logic              wr_b_en,
   input  logic [ADDR_W-1:0] wr_b_addr,
   input  logic [DATA_W-1:0] wr_b_data,
   input  logic              clr_req,
   output logic              busy,
   output logic              wr_collision
);

   localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic              coll_q, coll_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic busy_int;
   logic wa_valid, wb_valid, wb_commit, same_addr;
   logic [NUM_REGS-1:0] clr_hit, wa_hit, wb_hit;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      addr_ok = (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
   endfunction

   function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
      lookup = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a == ADDR_W'(i)) lookup = regs_q[i];
      end
      if (ZERO_REG && (a == '0)) lookup = '0;
   endfunction

   assign busy_int     = (state_q == ST_CLEAR);
   assign busy         = busy_int;
   assign wr_collision = coll_q;

   assign wa_valid  = wr_a_en && !busy_int && addr_ok(wr_a_addr);
   assign wb_valid  = wr_b_en && !busy_int && addr_ok(wr_b_addr);
   assign same_addr = (wr_a_addr == wr_b_addr);
   // Port A owns a shared address; port B is dropped and the clash is flagged.
   assign wb_commit = wb_valid && !(wa_valid && same_addr);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      coll_d    = wa_valid && wb_valid && same_addr;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_ptr_q == LAST_PTR) begin
               state_d   = ST_IDLE;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + PTR_W'(1);
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         coll_q    <= coll_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
         assign clr_hit[gi] = busy_int && (clr_ptr_q == PTR_W'(gi));
         assign wa_hit[gi]  = wa_valid && (wr_a_addr == ADDR_W'(gi));
         assign wb_hit[gi]  = wb_commit && (wr_b_addr == ADDR_W'(gi));
      end
   endgenerate

   // Storage carries no reset so it can map onto distributed RAM; clearing is sequential.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (clr_hit[i]) begin
            regs_q[i] <= '0;
         end else if (wa_hit[i]) begin
            regs_q[i] <= wr_a_data;
         end else if (wb_hit[i]) begin
            regs_q[i] <= wr_b_data;
         end
      end
   end

   always_comb begin
      rd_a_data = lookup(rd_a_addr);
      rd_b_data = lookup(rd_b_addr);
`ifdef REGFILE_BYPASS_EN
      // Port A is applied last so it overrides a matching port B forward.
      if (wb_commit && (wr_b_addr == rd_a_addr)) rd_a_data = wr_b_data;
      if (wa_valid && (wr_a_addr == rd_a_addr))  rd_a_data = wr_a_data;
      if (wb_commit && (wr_b_addr == rd_b_addr)) rd_b_data = wr_b_data;
      if (wa_valid && (wr_a_addr == rd_b_addr))  rd_b_data = wr_a_data;
`endif
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp against an array/countdown reference model.
`timescale 1ns/1ps
module tb_register_file_mp;
   localparam int N = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  ra, rb, waa, wba;
   logic [15:0] rda, rdb, wad, wbd;
   logic        wae, wbe, clr, busy, coll;

   logic [3:0]  z_ra, z_rb, z_waa, z_wba;
   logic [15:0] z_rda, z_rdb, z_wad, z_wbd;
   logic        z_wae, z_wbe, z_clr, z_busy, z_coll;

   register_file_mp dut (
      .clk(clk), .rst(rst),
      .rd_a_addr(ra), .rd_a_data(rda), .rd_b_addr(rb), .rd_b_data(rdb),
      .wr_a_en(wae), .wr_a_addr(waa), .wr_a_data(wad),
      .wr_b_en(wbe), .wr_b_addr(wba), .wr_b_data(wbd),
      .clr_req(clr), .busy(busy), .wr_collision(coll)
   );

   register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(1'b1)) dut_z (
      .clk(clk), .rst(rst),
      .rd_a_addr(z_ra), .rd_a_data(z_rda), .rd_b_addr(z_rb), .rd_b_data(z_rdb),
      .wr_a_en(z_wae), .wr_a_addr(z_waa), .wr_a_data(z_wad),
      .wr_b_en(z_wbe), .wr_b_addr(z_wba), .wr_b_data(z_wbd),
      .clr_req(z_clr), .busy(z_busy), .wr_collision(z_coll)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: register contents, cycles of clear still to run, collision flag.
   logic [15:0] mem_m [N];
   int          rem_m;
   bit          coll_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_rd(input logic [3:0] a);
      logic [15:0] v;
      v = mem_m[a];
`ifdef REGFILE_BYPASS_EN
      if (rem_m == 0 && !rst) begin
         if (wae && waa == a)      v = wad;
         else if (wbe && wba == a) v = wbd;
      end
`endif
      return v;
   endfunction

   // Inputs are set just after a falling edge; this checks, clocks once and updates the model.
   task automatic cycle();
      #1;
      check("busy", busy, rem_m != 0);
      check("collision", coll, coll_m);
      if (rem_m == 0) begin
         check("rd_a", rda, exp_rd(ra));
         check("rd_b", rdb, exp_rd(rb));
      end
      $display("cyc rst=%0b busy=%0b wa=%0b:%h=%h wb=%0b:%h=%h clr=%0b ra=%h->%h rb=%h->%h coll=%0b",
               rst, busy, wae, waa, wad, wbe, wba, wbd, clr, ra, rda, rb, rdb, coll);
      @(posedge clk);
      if (rst) begin
         rem_m  = N;
         coll_m = 1'b0;
      end else if (rem_m > 0) begin
         rem_m--;
         coll_m = 1'b0;
         if (rem_m == 0) foreach (mem_m[i]) mem_m[i] = '0;
      end else begin
         coll_m = wae && wbe && (waa == wba);
         if (wbe) mem_m[wba] = wbd;
         if (wae) mem_m[waa] = wad;
         if (clr) rem_m = N;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      wae = 1'b0; wbe = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst    = 1'b1;
      rem_m  = N;
      coll_m = 1'b0;
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      rst = 1'b1;
      ra = '0; rb = '0; waa = '0; wba = '0; wad = '0; wbd = '0;
      z_ra = '0; z_rb = '0; z_waa = '0; z_wba = '0; z_wad = '0; z_wbd = '0;
      z_wae = 1'b0; z_wbe = 1'b0; z_clr = 1'b0;
      idle();
      foreach (mem_m[i]) mem_m[i] = '0;
      rem_m = N; coll_m = 1'b0;
      @(negedge clk);

      // Reset, full clear length, all registers zero.
      do_reset(2);
      cnt = 0;
      while (busy && cnt < 40) begin cycle(); cnt++; end
      check("rst_busy_len", cnt, 16);
      for (int i = 0; i < N; i += 2) begin
         ra = 4'(i); rb = 4'(i + 1);
         cycle();
      end

      // Dual write to different addresses.
      wae = 1'b1; waa = 4'd3; wad = 16'h1234;
      wbe = 1'b1; wba = 4'd7; wbd = 16'hBEEF;
      ra = 4'd3; rb = 4'd7;
      cycle();
      idle();
      #1;
      check("dual_a", rda, 16'h1234);
      check("dual_b", rdb, 16'hBEEF);
      cycle();

      // Same-address collision: port A wins, one-cycle flag.
      wae = 1'b1; waa = 4'd5; wad = 16'hAAAA;
      wbe = 1'b1; wba = 4'd5; wbd = 16'h5555;
      ra = 4'd5;
      cycle();
      idle();
      #1;
      check("coll_reg5", rda, 16'hAAAA);
      check("coll_pulse", coll, 1'b1);
      cycle();
      #1;
      check("coll_drop", coll, 1'b0);
      cycle();

      // Read-during-write on address 2.
      ra = 4'd2;
      wae = 1'b1; waa = 4'd2; wad = 16'h0F0F;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("rdw_before", rda, 16'h0F0F);
`else
      check("rdw_before", rda, 16'h0000);
`endif
      cycle();
      idle();
      #1;
      check("rdw_after", rda, 16'h0F0F);
      cycle();

      // Fill, clear request, reset mid-clear at pointer 9, writes while busy dropped.
      for (int i = 0; i < N; i += 2) begin
         wae = 1'b1; waa = 4'(i);     wad = 16'hFFFF;
         wbe = 1'b1; wba = 4'(i + 1); wbd = 16'hFFFF;
         cycle();
      end
      idle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (9) cycle();
      do_reset(2);
      cnt = 0;
      while (busy && cnt < 40) begin
         wae = 1'b1; waa = 4'($urandom_range(0, 15)); wad = 16'($urandom);
         wbe = 1'b1; wba = 4'($urandom_range(0, 15)); wbd = 16'($urandom);
         clr = 1'($urandom);
         cycle();
         cnt++;
      end
      check("midclr_busy_len", cnt, 16);
      idle();
      for (int i = 0; i < N; i++) begin
         ra = 4'(i); rb = 4'(N - 1 - i);
         #1;
         check("midclr_zero", rda, 16'h0000);
         cycle();
      end

      // Randomised traffic with occasional clears.
      for (int k = 0; k < 400; k++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = ($urandom_range(0, 3) == 0) ? waa : 4'($urandom_range(0, 15));
         wae = 1'($urandom);
         waa = 4'($urandom_range(0, 15));
         wad = 16'($urandom);
         wbe = 1'($urandom);
         wba = ($urandom_range(0, 2) == 0) ? waa : 4'($urandom_range(0, 15));
         wbd = 16'($urandom);
         clr = ($urandom_range(0, 49) == 0);
         cycle();
      end
      idle();
      cnt = 0;
      while (rem_m > 0 && cnt < 40) begin cycle(); cnt++; end
      for (int i = 0; i < N; i += 2) begin
         ra = 4'(i); rb = 4'(i + 1);
         cycle();
      end

      // ZERO_REG instance with 12 registers: reg 0 and out-of-range addresses stay zero.
      z_wae = 1'b1; z_waa = 4'd0;  z_wad = 16'h1111;
      z_wbe = 1'b1; z_wba = 4'd13; z_wbd = 16'h1111;
      cycle();
      z_wae = 1'b0; z_wbe = 1'b0;
      z_ra = 4'd0; z_rb = 4'd13;
      #1;
      check("z_busy", z_busy, 1'b0);
      check("z_reg0", z_rda, 16'h0000);
      check("z_addr13", z_rdb, 16'h0000);
      z_wae = 1'b1; z_waa = 4'd11; z_wad = 16'h2222;
      z_wbe = 1'b1; z_wba = 4'd12; z_wbd = 16'h3333;
      cycle();
      z_wae = 1'b0; z_wbe = 1'b0;
      z_ra = 4'd11; z_rb = 4'd12;
      #1;
      check("z_reg11", z_rda, 16'h2222);
      check("z_addr12", z_rdb, 16'h0000);
      z_wae = 1'b1; z_waa = 4'd0; z_wad = 16'h4444;
      z_wbe = 1'b1; z_wba = 4'd0; z_wbd = 16'h5555;
      cycle();
      z_wae = 1'b0; z_wbe = 1'b0;
      z_ra = 4'd0;
      #1;
      check("z_no_coll", z_coll, 1'b0);
      check("z_reg0_again", z_rda, 16'h0000);
      cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
